// File: rtl/map_update_arbiter_if.sv
// map_update_arbiter_if
//   Bundles every signal of map_update_arbiter except Clk and Reset: the
//   vblank window, both player request/ack channels, the level-restore
//   handshake, and the map RAM / level ROM buses.
//   slave  : arbiter side (drives acks, result, busy, RAM/ROM addresses).
//   master : environment side (players, frame timing, RAM/ROM models).
//   score0/score1 exist only when HIT_COUNT_EN is defined.
interface map_update_arbiter_if;
  logic       vblank;
  logic       req0;
  logic       req1;
  logic [8:0] tile0;
  logic [8:0] tile1;
  logic       ack0;
  logic       ack1;
  logic [1:0] result;
  logic       load_req;
  logic       load_done;
  logic       busy;
  logic [8:0] map_addr;
  logic [2:0] map_rdata;
  logic       map_we;
  logic [2:0] map_wdata;
  logic [8:0] rom_addr;
  logic [2:0] rom_data;
`ifdef HIT_COUNT_EN
  logic [7:0] score0;
  logic [7:0] score1;
`endif

  modport slave (
    input  vblank, req0, req1, tile0, tile1, load_req, map_rdata, rom_data,
`ifdef HIT_COUNT_EN
    output score0, score1,
`endif
    output ack0, ack1, result, load_done, busy, map_addr, map_we, map_wdata,
           rom_addr
  );

  modport master (
    output vblank, req0, req1, tile0, tile1, load_req, map_rdata, rom_data,
`ifdef HIT_COUNT_EN
    input  score0, score1,
`endif
    input  ack0, ack1, result, load_done, busy, map_addr, map_we, map_wdata,
           rom_addr
  );
endinterface

// File: rtl/map_update_arbiter.sv
// map_update_arbiter
//   Serialises access to the 20x15 tile map between two players' bullet
//   impacts and a full level restore from ROM.
//   Ports:
//     Clk    - system clock
//     Reset  - synchronous, active-high reset
//     bus    - map_update_arbiter_if.slave: vblank, req0/req1, tile0/tile1,
//              ack0/ack1, result, load_req, load_done, busy, map RAM
//              (map_addr, map_rdata, map_we, map_wdata) and level ROM
//              (rom_addr, rom_data).
//   Optional: define HIT_COUNT_EN to add saturating per-player hit counters
//   score0/score1 (cleared on load_done).
//   Impact pipeline: IDLE grants and presents the tile address (p0), READ
//   sees the RAM data and writes back (p1), ACK returns the result (p2).
module map_update_arbiter (
  input  logic                 Clk,
  input  logic                 Reset,
  map_update_arbiter_if.slave  bus
);

  localparam logic [8:0] LAST_TILE = 9'd299;
  localparam logic [8:0] NUM_TILES = 9'd300;

  typedef enum logic [1:0] {IDLE, READ, ACK, LOAD} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rr;          // player favoured on contention
  logic       load_pend;   // load_req seen during READ/ACK
  logic [8:0] sweep_cnt;
  logic       load_done_q;

  logic       gnt_p1;      // granted player, held through ACK
  logic [8:0] tile_p1;
  logic       in_range_p1;
  logic [1:0] res_p2;

  logic       pick;
  logic [8:0] pick_tile;
  logic       load_go;
  logic [2:0] dec_p1;      // {write, result} for the current READ

  // Returns {write_enable, result} for a tile code read from the map.
  function automatic logic [2:0] impact_decode(input logic [2:0] code);
    case (code)
      3'd1:       return 3'b0_01;
      3'd2:       return 3'b1_10;
      3'd3, 3'd4: return 3'b1_11;
      default:    return 3'b0_00;
    endcase
  endfunction

  assign pick      = (bus.req0 && bus.req1) ? rr : bus.req1;
  assign pick_tile = pick ? bus.tile1 : bus.tile0;
  assign load_go   = bus.load_req || load_pend;
  assign dec_p1    = in_range_p1 ? impact_decode(bus.map_rdata) : 3'b000;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.map_addr  = 9'd0;
    bus.map_we    = 1'b0;
    bus.map_wdata = 3'd0;
    unique case (state)
      IDLE: begin
        if (load_go) begin
          state_nxt = LOAD;
        end else if (bus.vblank && (bus.req0 || bus.req1)) begin
          state_nxt    = READ;
          bus.map_addr = pick_tile;
        end
      end
      READ: begin
        bus.map_addr = tile_p1;
        bus.map_we   = dec_p1[2];
        state_nxt    = ACK;
      end
      ACK: state_nxt = IDLE;
      LOAD: begin
        bus.map_addr  = sweep_cnt;
        bus.map_we    = 1'b1;
        bus.map_wdata = bus.rom_data;
        if (sweep_cnt == LAST_TILE) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr          <= 1'b0;
      load_pend   <= 1'b0;
      sweep_cnt   <= 9'd0;
      load_done_q <= 1'b0;
      gnt_p1      <= 1'b0;
    end else begin
      load_done_q <= (state == LOAD) && (sweep_cnt == LAST_TILE);
      case (state)
        IDLE: begin
          if (load_go) begin
            load_pend <= 1'b0;
            sweep_cnt <= 9'd0;
          end else if (bus.vblank && (bus.req0 || bus.req1)) begin
            gnt_p1 <= pick;
            rr     <= ~pick;
          end
        end
        READ, ACK: if (bus.load_req) load_pend <= 1'b1;
        LOAD: sweep_cnt <= sweep_cnt + 9'd1;
        default: ;
      endcase
    end
  end

  // p0 -> p1: capture the granted tile; p1 -> p2: capture the result
  always_ff @(posedge Clk) begin
    if (state == IDLE) begin
      tile_p1     <= pick_tile;
      in_range_p1 <= (pick_tile < NUM_TILES);
    end
    if (state == READ) res_p2 <= dec_p1[1:0];
  end

  assign bus.ack0      = (state == ACK) && !gnt_p1;
  assign bus.ack1      = (state == ACK) &&  gnt_p1;
  assign bus.result    = (state == ACK) ? res_p2 : 2'd0;
  assign bus.busy      = (state != IDLE);
  assign bus.load_done = load_done_q;
  assign bus.rom_addr  = bus.map_addr;

`ifdef HIT_COUNT_EN
  logic [7:0] score0_q;
  logic [7:0] score1_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // res_p2[1] marks brick or base destroyed
  always_ff @(posedge Clk) begin
    if (Reset || load_done_q) begin
      score0_q <= 8'd0;
      score1_q <= 8'd0;
    end else begin
      if (bus.ack0 && res_p2[1]) score0_q <= sat_inc(score0_q);
      if (bus.ack1 && res_p2[1]) score1_q <= sat_inc(score1_q);
    end
  end

  assign bus.score0 = score0_q;
  assign bus.score1 = score1_q;
`endif

endmodule

// File: doc/map_update_arbiter.md
MAP_UPDATE_ARBITER -- requirements
Module: map_update_arbiter

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- vblank  in  1  high during vertical blanking; the only window in which a new player grant may start.
- req0 / req1  in  1 each  player bullet-impact request; held high until the matching ack.
- tile0 / tile1  in  9 each  impact tile index, row*20+col, legal range 0..299.
- ack0 / ack1  out  1 each  one-cycle completion pulse.
- result  out  2  impact result, valid only while an ack is high: 0 empty, 1 steel, 2 brick destroyed, 3 base destroyed.
- load_req  in  1  one-cycle pulse that starts a level restore.
- load_done  out  1  one-cycle pulse when the restore ends.
- busy  out  1  high in any state other than IDLE.
- map_addr  out  9  map RAM address.
- map_rdata  in  3  map RAM read data, valid one cycle after map_addr.
- map_we  out  1  map RAM write enable.
- map_wdata  out  3  map RAM write data.
- rom_addr  out  9  level ROM address; always equal to map_addr.
- rom_data  in  3  level ROM data, combinational.
REQ-002 Tile codes SHALL be: 0 empty, 1 steel, 2 brick, 3 base one, 4 base two; codes 5..7 SHALL be treated as empty.

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, ACK and LOAD.
REQ-004 Priority in IDLE SHALL be:
- load_req wins over any player request and enters LOAD.
- Otherwise, if vblank=1 and any req is high, one player is granted; map_addr=tile of that player; next state READ.
REQ-005 If req0 and req1 are high together, the player not served most recently SHALL win (round-robin); the rr pointer updates on each grant.
REQ-006 In READ, map_rdata decides the action:
- 2 (brick): map_we=1, map_wdata=0, result 2.
- 3 or 4 (base): map_we=1, map_wdata=0, result 3.
- 1 (steel): no write, result 1.
- else: no write, result 0.
REQ-007 In ACK, the block SHALL pulse the granted player's ack for exactly one cycle with result held stable, then return to IDLE.
- Grant-to-ack latency is exactly 2 cycles.
- A request still high on the following IDLE cycle is a new request.
REQ-008 A tile index >= 300 SHALL still be granted, SHALL NOT cause a RAM write, and SHALL be acknowledged with result 0 at the same latency.
REQ-009 A grant already started SHALL complete even if vblank falls.
REQ-010 The block SHALL NOT grant a player while vblank=0.
REQ-011 LOAD SHALL sweep map_addr 0..299, one address per cycle, with map_we=1 and map_wdata=rom_data.
- load_done pulses in the cycle after the address-299 write.
- The next state is IDLE.
REQ-012 load_req received during READ or ACK SHALL be latched and serviced on the next IDLE cycle; load_req received during LOAD SHALL be ignored.
REQ-013 Player requests arriving during LOAD SHALL wait; they are not dropped and not acked.
REQ-014 map_we SHALL never be high outside READ and LOAD.

Reset
REQ-015 On Reset, the following SHALL hold:
- State is IDLE.
- rr pointer favours player 0.
- ack0, ack1, load_done, busy, map_we, map_wdata, map_addr and result are all 0.
- Any latched load_req is cleared.
REQ-016 Reset asserted mid-LOAD or mid-READ SHALL abort the operation immediately with no further writes; partially restored map contents are left as they are.

Configuration
REQ-017 With HIT_COUNT_EN defined, the block SHALL add:
- Outputs score0 and score1, 8 bits each, reset to 0.
- Each increments by 1 on that player's ack with result 2 or 3, saturating at 255.
- Both clear on load_done.
REQ-018 Without HIT_COUNT_EN, score0 and score1 and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-019 Brick hit: map[45]=2, vblank=1, req0 with tile0=45.
- Required: ack0 two cycles after the grant, result=2, one write of 0 to address 45.
REQ-020 Contention: req0 and req1 high together with rr favouring player 0.
- Required: player 0 is acked first; player 1 is granted on the next IDLE cycle; with HIT_COUNT_EN, scores update accordingly.
REQ-021 Steel and out-of-range: tile 30 holds 1; request tile 30, then tile 310.
- Required: results 1 then 0; no map_we pulse for either.
REQ-022 Level restore: load_req while req1 is pending.
- Required: 300 consecutive writes mirroring the ROM, load_done pulse, then ack1 (vblank=1).
REQ-023 vblank gating: req0 raised with vblank=0.
- Required: no grant until vblank rises; a grant that starts before vblank falls still acks.
REQ-024 Reset at sweep address 150.
- Required: all outputs 0 on the next cycle, no writes afterwards, no load_done.
